// File: rtl/ps2_key_event_ctrl_pkg.sv
// Shared constants and types for the PS/2 key event controller.
package ps2_pkg;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    GAP
  } ps2_ctl_state_t;

  // One folded key event as seen by software.
  typedef struct packed {
    logic [7:0] rsvd;  // always zero
    logic [7:0] ext;   // E0 when the key is extended, else 00
    logic [7:0] brk;   // F0 when the key was released, else 00
    logic [7:0] code;  // scan code
  } key_evt_t;

endpackage

// File: rtl/ps2_key_event_ctrl_fifo.sv
// Synchronous show-ahead FIFO for key events. A write while full is accepted
// only when a read happens in the same cycle.
module key_evt_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign wr_ok   = wr_en & (~full | rd_en);
  assign rd_ok   = rd_en & ~empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_event_ctrl.sv
// Byte handshake with ps2_keyboard, E0/F0 prefix folding, optional typematic
// repeat filtering and an event FIFO for software to pop.
module ps2_key_event_ctrl
  import ps2_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter bit FILTER_REPEAT = 1'b1
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic                   en,
  input  logic                   ready,
  input  logic [7:0]             keydata,
  input  logic                   overflow,
  output logic                   nextdata_n,
  output logic                   ps2_rst,
  input  logic                   rd_en,
  output logic                   evt_valid,
  output logic [31:0]            evt_data,
  output logic [$clog2(DEPTH):0] evt_count,
  output logic                   lost,
  input  logic                   clr_lost
);

  ps2_ctl_state_t state, state_nxt;
  logic [7:0] byte_q;
  logic       ext_q, brk_q;
  logic [8:0] held_q;      // {ext, code} of the key currently held down
  logic       push_q;
  key_evt_t   evt_q;
  logic       ovf_q;
  logic       ovf_rise;
  logic       decode;
  logic       is_ext, is_brk, is_code, rep, emit;
  logic [8:0] cur;
  logic       fifo_full, fifo_empty;

  assign ovf_rise = overflow & ~ovf_q;
  // An overflow edge aborts the byte in flight, so no decode that cycle.
  assign decode   = (state == ACK) & ~ovf_rise;
  assign is_ext   = (byte_q == PS2_PFX_EXT);
  assign is_brk   = (byte_q == PS2_PFX_BRK);
  assign is_code  = ~is_ext & ~is_brk;
  assign cur      = {ext_q, byte_q};
  assign rep      = FILTER_REPEAT & ~brk_q & (cur == held_q);
  assign emit     = decode & en & is_code & ~rep;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!clrn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and ack strobe: one byte per IDLE->ACK->GAP round.
  always_comb begin
    state_nxt  = state;
    nextdata_n = 1'b1;
    if (ovf_rise) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (ready) state_nxt = ACK;
        ACK: begin
          nextdata_n = 1'b0;
          state_nxt  = GAP;
        end
        GAP:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Byte capture, prefix/held tracking and the registered push toward the FIFO.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      byte_q <= '0;
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      held_q <= '0;
      push_q <= 1'b0;
      evt_q  <= '0;
    end else begin
      if (state == IDLE && ready && !ovf_rise) byte_q <= keydata;
      push_q <= emit;
      if (emit) evt_q <= '{rsvd: 8'h00,
                           ext:  ext_q ? PS2_PFX_EXT : 8'h00,
                           brk:  brk_q ? PS2_PFX_BRK : 8'h00,
                           code: byte_q};
      if (ovf_rise) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (decode) begin
        if (!en) begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end else if (is_ext) begin
          ext_q <= 1'b1;
        end else if (is_brk) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
          if (FILTER_REPEAT) begin
            if (brk_q) begin
              if (cur == held_q) held_q <= '0;
            end else begin
              held_q <= cur;
            end
          end
        end
      end
    end
  end

  // Overflow edge detect, keyboard reset pulse and sticky lost flag.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      ovf_q   <= 1'b0;
      ps2_rst <= 1'b0;
      lost    <= 1'b0;
    end else begin
      ovf_q   <= overflow;
      ps2_rst <= ovf_rise;
      if (push_q && fifo_full && !rd_en) lost <= 1'b1;
      else if (clr_lost)                 lost <= 1'b0;
    end
  end

  key_evt_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .clrn    (clrn),
    .wr_en   (push_q),
    .wr_data (evt_q),
    .rd_en   (rd_en),
    .rd_data (evt_data),
    .count   (evt_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign evt_valid = ~fifo_empty;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench for ps2_key_event_ctrl: one filtering instance and one
// non-filtering instance share the same stimulus.
module tb_ps2_key_event_ctrl;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        en = 1'b1;
  logic        ready = 1'b0;
  logic [7:0]  keydata = 8'h00;
  logic        overflow = 1'b0;
  logic        rd_en = 1'b0;
  logic        clr_lost = 1'b0;

  logic        nextdata_n, ps2_rst, evt_valid, lost;
  logic [31:0] evt_data;
  logic [3:0]  evt_count;
  logic        nf_nextdata_n, nf_ps2_rst, nf_valid, nf_lost;
  logic [31:0] nf_data;
  logic [3:0]  nf_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ps2_key_event_ctrl #(.DEPTH(8), .FILTER_REPEAT(1'b1)) dut (
    .clk(clk), .clrn(clrn), .en(en), .ready(ready), .keydata(keydata),
    .overflow(overflow), .nextdata_n(nextdata_n), .ps2_rst(ps2_rst),
    .rd_en(rd_en), .evt_valid(evt_valid), .evt_data(evt_data),
    .evt_count(evt_count), .lost(lost), .clr_lost(clr_lost)
  );

  ps2_key_event_ctrl #(.DEPTH(8), .FILTER_REPEAT(1'b0)) dut_nf (
    .clk(clk), .clrn(clrn), .en(en), .ready(ready), .keydata(keydata),
    .overflow(overflow), .nextdata_n(nf_nextdata_n), .ps2_rst(nf_ps2_rst),
    .rd_en(rd_en), .evt_valid(nf_valid), .evt_data(nf_data),
    .evt_count(nf_count), .lost(nf_lost), .clr_lost(clr_lost)
  );

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b0; ready = 1'b0; rd_en = 1'b0; overflow = 1'b0; clr_lost = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clrn = 1'b1;
  endtask

  // One full IDLE/ACK/GAP round; the event lands in the FIFO one edge later.
  task automatic send(input logic [7:0] b);
    @(negedge clk); ready = 1'b1; keydata = b;
    @(negedge clk); ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk); rd_en = 1'b1;
    @(negedge clk); rd_en = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (nextdata_n !== 1'b1) begin failures++; $display("FAIL reset_nextdata_n got=%b exp=1", nextdata_n); end
    checks++; if (ps2_rst !== 1'b0)    begin failures++; $display("FAIL reset_ps2_rst got=%b exp=0", ps2_rst); end
    checks++; if (evt_valid !== 1'b0)  begin failures++; $display("FAIL reset_valid got=%b exp=0", evt_valid); end
    checks++; if (evt_data !== 32'h0)  begin failures++; $display("FAIL reset_data got=%h exp=0", evt_data); end
    checks++; if (evt_count !== 4'd0)  begin failures++; $display("FAIL reset_count got=%0d exp=0", evt_count); end
    checks++; if (lost !== 1'b0)       begin failures++; $display("FAIL reset_lost got=%b exp=0", lost); end
  endtask

  task automatic test_single();
    @(negedge clk); ready = 1'b1; keydata = 8'h1C;
    @(negedge clk); ready = 1'b0;
    checks++; if (nextdata_n !== 1'b0) begin failures++; $display("FAIL single_ack_low got=%b exp=0", nextdata_n); end
    checks++; if (evt_valid !== 1'b0)  begin failures++; $display("FAIL single_early1 got=%b exp=0", evt_valid); end
    @(negedge clk);
    checks++; if (nextdata_n !== 1'b1) begin failures++; $display("FAIL single_ack_release got=%b exp=1", nextdata_n); end
    checks++; if (evt_valid !== 1'b0)  begin failures++; $display("FAIL single_early2 got=%b exp=0", evt_valid); end
    @(negedge clk);
    checks++; if (evt_valid !== 1'b1)        begin failures++; $display("FAIL single_valid got=%b exp=1", evt_valid); end
    checks++; if (evt_data !== 32'h0000001C) begin failures++; $display("FAIL single_data got=%h exp=0000001c", evt_data); end
    checks++; if (evt_count !== 4'd1)        begin failures++; $display("FAIL single_count got=%0d exp=1", evt_count); end
    checks++; if (nextdata_n !== 1'b1)       begin failures++; $display("FAIL single_ack_once got=%b exp=1", nextdata_n); end
    pop();
    checks++; if (evt_count !== 4'd0)  begin failures++; $display("FAIL single_pop_count got=%0d exp=0", evt_count); end
    checks++; if (evt_data !== 32'h0)  begin failures++; $display("FAIL single_pop_data got=%h exp=0", evt_data); end
  endtask

  task automatic test_rd_empty();
    pop();
    checks++; if (evt_count !== 4'd0) begin failures++; $display("FAIL rd_empty_count got=%0d exp=0", evt_count); end
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL rd_empty_valid got=%b exp=0", evt_valid); end
  endtask

  task automatic test_prefix();
    send(8'hF0); settle();
    checks++; if (evt_count !== 4'd0) begin failures++; $display("FAIL prefix_none got=%0d exp=0", evt_count); end
    send(8'h1C); settle();
    checks++; if (evt_data !== 32'h0000F01C) begin failures++; $display("FAIL prefix_brk got=%h exp=0000f01c", evt_data); end
    checks++; if (evt_count !== 4'd1)        begin failures++; $display("FAIL prefix_brk_count got=%0d exp=1", evt_count); end
    pop();
    send(8'hE0); send(8'hF0); send(8'h75); settle();
    checks++; if (evt_data !== 32'h00E0F075) begin failures++; $display("FAIL prefix_ext_brk got=%h exp=00e0f075", evt_data); end
    checks++; if (evt_count !== 4'd1)        begin failures++; $display("FAIL prefix_ext_count got=%0d exp=1", evt_count); end
    pop();
  endtask

  task automatic test_repeat();
    do_reset();
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    settle();
    checks++; if (evt_count !== 4'd3) begin failures++; $display("FAIL repeat_count got=%0d exp=3", evt_count); end
    checks++; if (nf_count !== 4'd5)  begin failures++; $display("FAIL norepeat_count got=%0d exp=5", nf_count); end
    checks++; if (evt_data !== 32'h0000001C) begin failures++; $display("FAIL repeat_evt0 got=%h exp=0000001c", evt_data); end
    pop();
    checks++; if (evt_data !== 32'h0000F01C) begin failures++; $display("FAIL repeat_evt1 got=%h exp=0000f01c", evt_data); end
    pop();
    checks++; if (evt_data !== 32'h0000001C) begin failures++; $display("FAIL repeat_evt2 got=%h exp=0000001c", evt_data); end
    pop();
    checks++; if (evt_count !== 4'd0) begin failures++; $display("FAIL repeat_drained got=%0d exp=0", evt_count); end
    checks++; if (nf_data !== 32'h0000F01C) begin failures++; $display("FAIL norepeat_head got=%h exp=0000f01c", nf_data); end
    checks++; if (nf_count !== 4'd2)  begin failures++; $display("FAIL norepeat_left got=%0d exp=2", nf_count); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 1; i <= 10; i++) send(8'(i));
    settle();
    checks++; if (evt_count !== 4'd8) begin failures++; $display("FAIL full_count got=%0d exp=8", evt_count); end
    checks++; if (lost !== 1'b1)      begin failures++; $display("FAIL full_lost got=%b exp=1", lost); end
    checks++; if (evt_data !== 32'h00000001) begin failures++; $display("FAIL full_head got=%h exp=00000001", evt_data); end
    @(negedge clk); clr_lost = 1'b1;
    @(negedge clk); clr_lost = 1'b0;
    checks++; if (lost !== 1'b0) begin failures++; $display("FAIL clr_lost got=%b exp=0", lost); end
  endtask

  task automatic test_full_pushpop();
    logic [31:0] exp;
    @(negedge clk); ready = 1'b1; keydata = 8'h0B;
    @(negedge clk); ready = 1'b0;
    @(negedge clk); rd_en = 1'b1;   // push lands on the coming edge
    @(negedge clk); rd_en = 1'b0;
    checks++; if (evt_count !== 4'd8) begin failures++; $display("FAIL pushpop_count got=%0d exp=8", evt_count); end
    checks++; if (evt_data !== 32'h00000002) begin failures++; $display("FAIL pushpop_head got=%h exp=00000002", evt_data); end
    checks++; if (lost !== 1'b0) begin failures++; $display("FAIL pushpop_lost got=%b exp=0", lost); end
    for (int i = 0; i < 8; i++) begin
      exp = (i < 7) ? 32'(i + 2) : 32'h0000000B;
      checks++; if (evt_data !== exp) begin failures++; $display("FAIL drain_%0d got=%h exp=%h", i, evt_data, exp); end
      pop();
    end
    checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", evt_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    send(8'hE0);
    @(negedge clk); overflow = 1'b1;
    @(negedge clk);
    checks++; if (ps2_rst !== 1'b1)    begin failures++; $display("FAIL ovf_pulse got=%b exp=1", ps2_rst); end
    checks++; if (nextdata_n !== 1'b1) begin failures++; $display("FAIL ovf_nextdata got=%b exp=1", nextdata_n); end
    @(negedge clk);
    checks++; if (ps2_rst !== 1'b0)    begin failures++; $display("FAIL ovf_one_cycle got=%b exp=0", ps2_rst); end
    @(negedge clk);
    checks++; if (ps2_rst !== 1'b0)    begin failures++; $display("FAIL ovf_held got=%b exp=0", ps2_rst); end
    overflow = 1'b0;
    send(8'h74); settle();
    checks++; if (evt_data !== 32'h00000074) begin failures++; $display("FAIL ovf_ext_cleared got=%h exp=00000074", evt_data); end
    checks++; if (evt_count !== 4'd1) begin failures++; $display("FAIL ovf_count got=%0d exp=1", evt_count); end
  endtask

  task automatic test_reset_mid();
    send(8'hF0);
    do_reset();
    send(8'h1C); settle();
    checks++; if (evt_data !== 32'h0000001C) begin failures++; $display("FAIL rstmid_data got=%h exp=0000001c", evt_data); end
    checks++; if (evt_count !== 4'd1) begin failures++; $display("FAIL rstmid_count got=%0d exp=1", evt_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rd_empty();
    test_prefix();
    test_repeat();
    test_full();
    test_full_pushpop();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
